ps2_key_sequencer: RTL and testbench
====================================

// Module: ps2_key_sequencer
// PURPOSE
//  Sits between the PS/2 byte receiver and the scan-code decoder feeding the VGA colour/quadrant
//  select. Parses raw scan-code bytes (E0/F0 prefixes), suppresses typematic repeats of a held key
//  and queues accepted make codes in a small FIFO. Presents codes to the decoder side with a
//  valid/ready handshake, so key presses are applied one at a time (e.g. at frame boundaries).
// PARAMETERS
//  FIFO_DEPTH      4      make-code queue depth; power of 2, >=2
//  TIMEOUT_CYCLES  50000  inter-byte prefix timeout in clk cycles (only with PS2_TIMEOUT_EN)
// PORTS
//  clk        in   1  system clock
//  reset      in   1  reset, asynchronous, active-high
//  rx_byte    in   8  received scan-code byte; valid only while rx_valid=1
//  rx_valid   in   1  one-cycle strobe, rx_byte complete and parity-good
//  rx_err     in   1  one-cycle strobe, framing/parity error on current byte
//  key_code   out  8  FIFO head make code (to decoder ps2InCode)
//  key_valid  out  1  FIFO non-empty
//  key_ready  in   1  consumer accepts key_code this cycle
//  fifo_count out  $clog2(FIFO_DEPTH)+1  entries queued
//  overflow   out  1  sticky: make code dropped because FIFO was full
//  ovf_clr    in   1  clears overflow (one-cycle pulse)
// BEHAVIOUR
//  Reset (async): FSM=S_IDLE, FIFO empty, key_code=8'h00, key_valid=0, fifo_count=0, overflow=0,
//   held_vld=0, held_code=8'h00. Reset mid-byte-sequence discards any pending prefix.
//  FSM, advances only on rx_valid:
//   S_IDLE:    E0->S_EXT; F0->S_BRK; AA/FA/FE/EE/00/FF ignored, stay; else MAKE(b), stay.
//   S_EXT:     F0->S_EXT_BRK; else byte discarded (extended makes unsupported) -> S_IDLE.
//   S_BRK:     RELEASE(b) -> S_IDLE.
//   S_EXT_BRK: byte discarded -> S_IDLE.
//   rx_err in any state: byte ignored, FSM -> S_IDLE; held state unchanged.
//   rx_err and rx_valid same cycle: rx_err wins.
//  MAKE(b): if held_vld && held_code==b -> dropped (typematic repeat). Else push b,
//   held_code<=b, held_vld<=1 (held_* update even if the push overflows).
//  RELEASE(b): if held_code==b -> held_vld<=0; else no effect.
//  FIFO: push on accepted MAKE; pop when key_valid && key_ready.
//   Latency: rx_valid at cycle N -> key_valid/key_code updated at N+1 (registered, empty FIFO).
//   key_code/key_valid hold stable while key_valid && !key_ready.
//   Push while full and no pop: code dropped, overflow<=1 next cycle.
//   Push and pop same cycle when full: both occur, no overflow, count unchanged.
//   Push and pop same cycle when count=1: new code becomes head, count stays 1.
//   key_ready while empty: no effect. Pointers wrap modulo FIFO_DEPTH.
//   Empty FIFO: key_code holds last popped value (8'h00 after reset).
//  overflow: set has priority over ovf_clr in the same cycle.
// CONFIGURATION
//  PS2_TIMEOUT_EN defined: counter loads 0 on each rx_valid, increments while FSM != S_IDLE,
//   saturates; reaching TIMEOUT_CYCLES-1 forces FSM -> S_IDLE (pending prefix discarded,
//   held state unchanged). Counter is held at 0 in S_IDLE.
//  PS2_TIMEOUT_EN undefined: no counter; prefix states wait indefinitely for the next byte.
// TESTING
//  Reset: assert reset mid-clock -> key_valid=0, key_code=8'h00, fifo_count=0, overflow=0.
//  Bytes 16,16,16,F0,16,16 with key_ready=0 -> fifo_count=2, codes 16,16 pop in order.
//  Bytes E0,2D then E0,F0,2D then 1E -> only 1E queued, key_valid at 1 cycle after strobe.
//  FIFO_DEPTH=4, key_ready=0, makes 16,1E,26,25,2D -> count=4, overflow=1, 2D dropped;
//   ovf_clr -> overflow=0.
//  Full FIFO, push 34 with key_ready=1 same cycle -> pop 16, count=4, overflow stays 0.
//  PS2_TIMEOUT_EN: F0 then idle TIMEOUT_CYCLES -> S_IDLE; next 32 is queued as a make.

Source files
------------

// File: rtl/ps2_key_sequencer.sv
// ps2_key_sequencer
// ----------------------------------------------------------------------------
// Sits between the PS/2 byte receiver and the scan-code decoder that drives the
// VGA colour/quadrant select. It does four jobs:
//   - parses raw scan-code bytes, including the E0 (extended) and F0 (break)
//     prefixes
//   - suppresses typematic repeats of the key that is currently held down
//   - queues accepted make codes in a small FIFO
//   - presents the FIFO head to the decoder with a valid/ready handshake, so
//     key presses can be applied one at a time (for example at frame
//     boundaries)
//
// Parameters
//   FIFO_DEPTH      make-code queue depth (power of 2, >= 2)
//   TIMEOUT_CYCLES  inter-byte prefix timeout in clk cycles (only used when
//                   PS2_TIMEOUT_EN is defined)
//
// Optional feature macro
//   PS2_TIMEOUT_EN  When defined, a pending prefix (E0 / F0 / E0 F0) is
//                   abandoned if no further byte arrives within TIMEOUT_CYCLES.
//                   When undefined, prefix states wait indefinitely.
//
// Ports
//   clk         in   system clock
//   reset       in   asynchronous, active-high reset
//   rx_byte     in   [7:0] received scan-code byte, valid while rx_valid=1
//   rx_valid    in   one-cycle strobe: rx_byte complete and parity-good
//   rx_err      in   one-cycle strobe: framing/parity error on current byte
//   key_code    out  [7:0] FIFO head make code (holds last popped value when
//                    the FIFO is empty)
//   key_valid   out  FIFO non-empty
//   key_ready   in   consumer accepts key_code this cycle
//   fifo_count  out  [$clog2(FIFO_DEPTH):0] number of queued entries
//   overflow    out  sticky: a make code was dropped because the FIFO was full
//   ovf_clr     in   one-cycle pulse that clears overflow
// ----------------------------------------------------------------------------
module ps2_key_sequencer #(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [7:0]                  rx_byte,
  input  logic                        rx_valid,
  input  logic                        rx_err,
  output logic [7:0]                  key_code,
  output logic                        key_valid,
  input  logic                        key_ready,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        overflow,
  input  logic                        ovf_clr
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  localparam logic [CW-1:0] COUNT_FULL = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] COUNT_ONE  = CW'(1);
  localparam logic [AW-1:0] PTR_ONE    = AW'(1);

  // Parser states
  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_EXT     = 2'd1;
  localparam logic [1:0] S_BRK     = 2'd2;
  localparam logic [1:0] S_EXT_BRK = 2'd3;

  localparam logic [7:0] BYTE_EXT = 8'hE0;
  localparam logic [7:0] BYTE_BRK = 8'hF0;

  // Reject parameter values the pointer arithmetic cannot handle, at
  // elaboration time.
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
      TIMEOUT_CYCLES < 2) begin : g_param_check
    $error("ps2_key_sequencer: bad FIFO_DEPTH or TIMEOUT_CYCLES");
  end

  logic [1:0]    state;
  logic [1:0]    state_next;
  logic          make_evt;
  logic          rel_evt;
  logic          ignored_byte;
  logic          timeout_hit;

  logic [7:0]    held_code;
  logic          held_vld;
  logic          typematic;
  logic          make_accept;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] rd_ptr_inc;
  logic          full;
  logic          pop;
  logic          push_ok;
  logic          ovf_set;

  // Keyboard housekeeping replies (self-test pass, ack, resend, echo,
  // buffer error). They carry no key information and are never treated as
  // make codes.
  always_comb begin
    ignored_byte = 1'b0;
    case (rx_byte)
      8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF: ignored_byte = 1'b1;
      default:                                  ignored_byte = 1'b0;
    endcase
  end

  // Prefix parser. It only moves on a received byte. An rx_err strobe always
  // drops back to idle and discards the byte, even if rx_valid is high in
  // the same cycle. The optional timeout also returns to idle, but only on
  // cycles with no byte activity.
  always_comb begin
    state_next = state;
    make_evt   = 1'b0;
    rel_evt    = 1'b0;
    if (rx_err) begin
      state_next = S_IDLE;
    end else if (rx_valid) begin
      case (state)
        S_IDLE: begin
          if (rx_byte == BYTE_EXT) begin
            state_next = S_EXT;
          end else if (rx_byte == BYTE_BRK) begin
            state_next = S_BRK;
          end else if (!ignored_byte) begin
            make_evt = 1'b1;
          end
        end
        S_EXT: begin
          // Extended make codes are not supported by the decoder, so they
          // are dropped here.
          if (rx_byte == BYTE_BRK) begin
            state_next = S_EXT_BRK;
          end else begin
            state_next = S_IDLE;
          end
        end
        S_BRK: begin
          rel_evt    = 1'b1;
          state_next = S_IDLE;
        end
        S_EXT_BRK: begin
          state_next = S_IDLE;
        end
        default: begin
          state_next = S_IDLE;
        end
      endcase
    end else if (timeout_hit) begin
      state_next = S_IDLE;
    end
  end

  // Parser state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

`ifdef PS2_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [TW-1:0] TMO_LIMIT = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] tmo_cnt;

  // Inter-byte timer. It restarts on every received byte and is held at
  // zero while idle. It saturates at all-ones so that it cannot wrap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tmo_cnt <= '0;
    end else if (rx_valid || state == S_IDLE) begin
      tmo_cnt <= '0;
    end else if (tmo_cnt != '1) begin
      tmo_cnt <= tmo_cnt + TW'(1);
    end
  end

  assign timeout_hit = (state != S_IDLE) && (tmo_cnt == TMO_LIMIT);
`else
  assign timeout_hit = 1'b0;
`endif

  // A make code equal to the held key is an auto-repeat and is dropped.
  // Every other make is accepted, whether or not the FIFO has room for it.
  assign typematic   = held_vld && (held_code == rx_byte);
  assign make_accept = make_evt && !typematic;

  // Held-key tracker. It follows accepted makes even when the push is lost
  // to overflow, so that later repeats of that key are still suppressed. A
  // release only clears it when the release matches the held key.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      held_code <= 8'h00;
      held_vld  <= 1'b0;
    end else if (make_accept) begin
      held_code <= rx_byte;
      held_vld  <= 1'b1;
    end else if (rel_evt && held_code == rx_byte) begin
      held_vld  <= 1'b0;
    end
  end

  // FIFO control. A full FIFO still accepts a push in a cycle where the
  // head is popped, because a slot frees up in that same cycle.
  assign key_valid  = (fifo_count != '0);
  assign full       = (fifo_count == COUNT_FULL);
  assign pop        = key_valid && key_ready;
  assign push_ok    = make_accept && (!full || pop);
  assign ovf_set    = make_accept && full && !pop;
  assign rd_ptr_inc = rd_ptr + PTR_ONE;

  // FIFO storage. There is no reset here: every slot is written before it
  // can be read.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= rx_byte;
    end
  end

  // FIFO pointers and occupancy. The pointers wrap naturally because the
  // depth is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr_inc;
      end
      case ({push_ok, pop})
        2'b10:   fifo_count <= fifo_count + COUNT_ONE;
        2'b01:   fifo_count <= fifo_count - COUNT_ONE;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Registered head of the FIFO. It is loaded with the entry that will be
  // at the head after this cycle's push/pop:
  //   - pop with more entries behind it: the next stored entry
  //   - pop of the last entry together with a push: the incoming byte
  //   - push into an empty FIFO: the incoming byte
  // In every other case it holds, so an empty FIFO keeps showing the last
  // popped code.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      key_code <= 8'h00;
    end else if (pop && fifo_count > COUNT_ONE) begin
      key_code <= mem[rd_ptr_inc];
    end else if (pop && push_ok) begin
      key_code <= rx_byte;
    end else if (!key_valid && push_ok) begin
      key_code <= rx_byte;
    end
  end

  // Sticky overflow flag. When a drop and a clear happen in the same cycle,
  // the drop wins, so a lost code is never hidden.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (ovf_set) begin
      overflow <= 1'b1;
    end else if (ovf_clr) begin
      overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ps2_key_sequencer.sv
// tb_ps2_key_sequencer
// ----------------------------------------------------------------------------
// Directed testbench for ps2_key_sequencer with FIFO_DEPTH=4. Inputs change on
// the falling clock edge and outputs are checked on the falling edge, half a
// cycle away from the rising edge where the DUT registers its state.
// Build with +define+PS2_TIMEOUT_EN to exercise the prefix timeout.
// ----------------------------------------------------------------------------
module tb_ps2_key_sequencer;

  localparam int DEPTH = 4;
  localparam int TMO   = 50;

  logic       clk;
  logic       reset;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       rx_err;
  logic [7:0] key_code;
  logic       key_valid;
  logic       key_ready;
  logic [2:0] fifo_count;
  logic       overflow;
  logic       ovf_clr;

  int checks;
  int passes;

  ps2_key_sequencer #(
    .FIFO_DEPTH    (DEPTH),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .rx_byte   (rx_byte),
    .rx_valid  (rx_valid),
    .rx_err    (rx_err),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .fifo_count(fifo_count),
    .overflow  (overflow),
    .ovf_clr   (ovf_clr)
  );

  // 100 MHz clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Present one byte as a one-cycle rx_valid strobe. Returns on the falling
  // edge right after the rising edge that consumed the byte.
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_byte  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  // One-cycle key_ready pulse
  task automatic pop_one();
    @(negedge clk);
    key_ready = 1'b1;
    @(negedge clk);
    key_ready = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Assert reset in the middle of a pending F0 prefix with a code queued.
  // The next 16 must be treated as a fresh make.
  task automatic test_reset();
    send_byte(8'h16);
    send_byte(8'hF0);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    checks++;
    if (key_valid !== 1'b0) $display("[TB] FAIL reset_key_valid got %b exp 0", key_valid);
    else passes++;
    checks++;
    if (key_code !== 8'h00) $display("[TB] FAIL reset_key_code got %h exp 00", key_code);
    else passes++;
    checks++;
    if (fifo_count !== 3'd0) $display("[TB] FAIL reset_count got %0d exp 0", fifo_count);
    else passes++;
    checks++;
    if (overflow !== 1'b0) $display("[TB] FAIL reset_overflow got %b exp 0", overflow);
    else passes++;
    @(negedge clk);
    reset = 1'b0;
    send_byte(8'h16);
    checks++;
    if (fifo_count !== 3'd1 || key_code !== 8'h16)
      $display("[TB] FAIL reset_prefix_discard got count=%0d code=%h exp count=1 code=16",
               fifo_count, key_code);
    else passes++;
  endtask

  // Auto-repeats of the held key are dropped. After the key is released, the
  // same key is accepted again.
  task automatic test_typematic();
    do_reset();
    send_byte(8'h16);
    send_byte(8'h16);
    send_byte(8'h16);
    send_byte(8'hF0);
    send_byte(8'h16);
    send_byte(8'h16);
    checks++;
    if (fifo_count !== 3'd2) $display("[TB] FAIL typematic_count got %0d exp 2", fifo_count);
    else passes++;
    checks++;
    if (key_code !== 8'h16) $display("[TB] FAIL typematic_head0 got %h exp 16", key_code);
    else passes++;
    pop_one();
    checks++;
    if (fifo_count !== 3'd1 || key_code !== 8'h16)
      $display("[TB] FAIL typematic_head1 got count=%0d code=%h exp count=1 code=16",
               fifo_count, key_code);
    else passes++;
    pop_one();
    checks++;
    if (key_valid !== 1'b0 || fifo_count !== 3'd0 || key_code !== 8'h16)
      $display("[TB] FAIL typematic_empty got v=%b count=%0d code=%h exp v=0 count=0 code=16",
               key_valid, fifo_count, key_code);
    else passes++;
    // A pop request while empty must not change anything
    pop_one();
    checks++;
    if (fifo_count !== 3'd0 || key_code !== 8'h16)
      $display("[TB] FAIL ready_while_empty got count=%0d code=%h exp count=0 code=16",
               fifo_count, key_code);
    else passes++;
  endtask

  // Extended makes and breaks are discarded. A normal make shows up one
  // cycle after its strobe.
  task automatic test_extended();
    do_reset();
    send_byte(8'hE0);
    send_byte(8'h2D);
    checks++;
    if (fifo_count !== 3'd0) $display("[TB] FAIL ext_make_count got %0d exp 0", fifo_count);
    else passes++;
    send_byte(8'hE0);
    send_byte(8'hF0);
    send_byte(8'h2D);
    checks++;
    if (fifo_count !== 3'd0) $display("[TB] FAIL ext_break_count got %0d exp 0", fifo_count);
    else passes++;
    @(negedge clk);
    rx_byte  = 8'h1E;
    rx_valid = 1'b1;
    #1;
    checks++;
    if (key_valid !== 1'b0) $display("[TB] FAIL latency_same_cycle got %b exp 0", key_valid);
    else passes++;
    @(negedge clk);
    rx_valid = 1'b0;
    checks++;
    if (key_valid !== 1'b1 || key_code !== 8'h1E || fifo_count !== 3'd1)
      $display("[TB] FAIL latency_next_cycle got v=%b code=%h count=%0d exp v=1 code=1E count=1",
               key_valid, key_code, fifo_count);
    else passes++;
  endtask

  // Fill the FIFO, overflow it, check that a drop beats a clear in the same
  // cycle, then do a push and a pop together while full and drain the FIFO.
  task automatic test_overflow();
    logic [7:0] exp_order [4];
    exp_order[0] = 8'h1E;
    exp_order[1] = 8'h26;
    exp_order[2] = 8'h25;
    exp_order[3] = 8'h34;
    do_reset();
    send_byte(8'h16);
    send_byte(8'h1E);
    send_byte(8'h26);
    send_byte(8'h25);
    checks++;
    if (fifo_count !== 3'd4 || overflow !== 1'b0)
      $display("[TB] FAIL full_no_ovf got count=%0d ovf=%b exp count=4 ovf=0",
               fifo_count, overflow);
    else passes++;
    send_byte(8'h2D);
    checks++;
    if (fifo_count !== 3'd4 || overflow !== 1'b1 || key_code !== 8'h16)
      $display("[TB] FAIL overflow_set got count=%0d ovf=%b code=%h exp count=4 ovf=1 code=16",
               fifo_count, overflow, key_code);
    else passes++;
    @(negedge clk);
    rx_byte  = 8'h2E;
    rx_valid = 1'b1;
    ovf_clr  = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    ovf_clr  = 1'b0;
    checks++;
    if (overflow !== 1'b1) $display("[TB] FAIL ovf_set_beats_clr got %b exp 1", overflow);
    else passes++;
    @(negedge clk);
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    checks++;
    if (overflow !== 1'b0) $display("[TB] FAIL ovf_clr got %b exp 0", overflow);
    else passes++;
    @(negedge clk);
    rx_byte   = 8'h34;
    rx_valid  = 1'b1;
    key_ready = 1'b1;
    @(negedge clk);
    rx_valid  = 1'b0;
    key_ready = 1'b0;
    checks++;
    if (fifo_count !== 3'd4 || overflow !== 1'b0 || key_code !== 8'h1E)
      $display("[TB] FAIL full_push_pop got count=%0d ovf=%b code=%h exp count=4 ovf=0 code=1E",
               fifo_count, overflow, key_code);
    else passes++;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (key_code !== exp_order[i])
        $display("[TB] FAIL drain_order[%0d] got %h exp %h", i, key_code, exp_order[i]);
      else passes++;
      pop_one();
    end
    checks++;
    if (fifo_count !== 3'd0 || key_valid !== 1'b0)
      $display("[TB] FAIL drain_empty got count=%0d v=%b exp count=0 v=0", fifo_count, key_valid);
    else passes++;
  endtask

  // A push and a pop in the same cycle with one entry: the new code becomes
  // the head.
  task automatic test_push_pop_count1();
    do_reset();
    send_byte(8'h16);
    @(negedge clk);
    rx_byte   = 8'h1E;
    rx_valid  = 1'b1;
    key_ready = 1'b1;
    @(negedge clk);
    rx_valid  = 1'b0;
    key_ready = 1'b0;
    checks++;
    if (fifo_count !== 3'd1 || key_code !== 8'h1E)
      $display("[TB] FAIL count1_push_pop got count=%0d code=%h exp count=1 code=1E",
               fifo_count, key_code);
    else passes++;
  endtask

  // rx_err drops any pending prefix and overrides rx_valid. Housekeeping
  // bytes are ignored.
  task automatic test_error();
    do_reset();
    send_byte(8'hF0);
    @(negedge clk);
    rx_byte = 8'h16;
    rx_err  = 1'b1;
    @(negedge clk);
    rx_err  = 1'b0;
    send_byte(8'h16);
    checks++;
    if (fifo_count !== 3'd1 || key_code !== 8'h16)
      $display("[TB] FAIL err_clears_prefix got count=%0d code=%h exp count=1 code=16",
               fifo_count, key_code);
    else passes++;
    @(negedge clk);
    rx_byte  = 8'h1E;
    rx_valid = 1'b1;
    rx_err   = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_err   = 1'b0;
    checks++;
    if (fifo_count !== 3'd1) $display("[TB] FAIL err_beats_valid got %0d exp 1", fifo_count);
    else passes++;
    send_byte(8'hAA);
    send_byte(8'hFA);
    checks++;
    if (fifo_count !== 3'd1) $display("[TB] FAIL ignored_bytes got %0d exp 1", fifo_count);
    else passes++;
    send_byte(8'h1E);
    checks++;
    if (fifo_count !== 3'd2) $display("[TB] FAIL make_after_err got %0d exp 2", fifo_count);
    else passes++;
  endtask

  // Leave an F0 pending for longer than the timeout. With the timeout built
  // in, the next byte is a make. Without it, the next byte is a release.
  task automatic test_timeout();
    do_reset();
    send_byte(8'hF0);
    repeat (TMO + 10) @(negedge clk);
    send_byte(8'h32);
`ifdef PS2_TIMEOUT_EN
    checks++;
    if (fifo_count !== 3'd1 || key_code !== 8'h32)
      $display("[TB] FAIL timeout_make got count=%0d code=%h exp count=1 code=32",
               fifo_count, key_code);
    else passes++;
`else
    checks++;
    if (fifo_count !== 3'd0) $display("[TB] FAIL no_timeout_release got %0d exp 0", fifo_count);
    else passes++;
`endif
  endtask

  initial begin
    checks    = 0;
    passes    = 0;
    reset     = 1'b1;
    rx_byte   = 8'h00;
    rx_valid  = 1'b0;
    rx_err    = 1'b0;
    key_ready = 1'b0;
    ovf_clr   = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    test_reset();
    test_typematic();
    test_extended();
    test_overflow();
    test_push_pop_count1();
    test_error();
    test_timeout();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
